// File: rtl/imm_encoder.sv
// RV32I instruction packer: immediate + fields -> I/U/S/B/J/load word, with `li` expanded to LUI/ADDI.
// Define IMMENC_RANGE_CHECK_EN to flag out-of-range immediates and enable the saturating err_cnt.
module imm_encoder #(
  parameter logic [31:0] NOP_WORD = 32'h00000013,
  parameter int          CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [31:0]      in_imm,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_last,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_U   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_J   = 3'd4,
    FMT_L   = 3'd5,
    FMT_LI  = 3'd6,
    FMT_BAD = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    HOLD1 = 2'd2
  } state_e;

  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [31:0] second_q, second_d;

  logic [31:0] enc_word;
  logic [31:0] enc_second;
  logic        enc_two;
  logic        enc_err;
  logic [19:0] li_hi;
  logic        accept;

  assign li_hi = in_imm[31:12] + {19'd0, in_imm[11]};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    enc_word   = NOP_WORD;
    enc_second = NOP_WORD;
    enc_two    = 1'b0;
    enc_err    = 1'b0;
    unique case (fmt_e'(in_sel))
      FMT_I, FMT_L: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_U:        enc_word = {in_imm[31:12], in_rd, in_opcode};
      FMT_S:        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B:        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:1], in_imm[11], in_opcode};
      FMT_J:        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      FMT_LI: begin
        if (li_hi == 20'd0) begin
          enc_word = {in_imm[11:0], 5'd0, 3'b000, in_rd, OP_ADDI};
        end else begin
          enc_word   = {li_hi, in_rd, OP_LUI};
          enc_second = {in_imm[11:0], in_rd, 3'b000, in_rd, OP_ADDI};
          enc_two    = (in_imm[11:0] != 12'd0);
        end
      end
      default: enc_err = 1'b1;
    endcase
`ifdef IMMENC_RANGE_CHECK_EN
    // Sign-extension checks: the bits dropped by each format must be copies of its sign bit.
    unique case (fmt_e'(in_sel))
      FMT_I, FMT_L, FMT_S: if (!(&in_imm[31:11] || ~|in_imm[31:11])) enc_err = 1'b1;
      FMT_B: if (!(&in_imm[31:12] || ~|in_imm[31:12]) || in_imm[0]) enc_err = 1'b1;
      FMT_J: if (!(&in_imm[31:20] || ~|in_imm[31:20]) || in_imm[0]) enc_err = 1'b1;
      FMT_U: if (in_imm[11:0] != 12'd0) enc_err = 1'b1;
      default: ;
    endcase
`endif
  end

  assign in_ready  = (state_q == IDLE) || (state_q == HOLD && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q != IDLE);
  assign out_instr = instr_q;
  assign out_last  = last_q;
  assign out_err   = err_q;

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    last_d   = last_q;
    err_d    = err_q;
    second_d = second_q;
    if (accept) begin
      instr_d  = enc_word;
      last_d   = !enc_two;
      err_d    = enc_err;
      second_d = enc_second;
      state_d  = enc_two ? HOLD1 : HOLD;
    end else begin
      unique case (state_q)
        HOLD:  if (out_ready) state_d = IDLE;
        HOLD1: if (out_ready) begin
          // LI is always in range, so the trailing ADDI never carries an error.
          instr_d = second_q;
          last_d  = 1'b1;
          err_d   = 1'b0;
          state_d = HOLD;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      second_q <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      last_q   <= last_d;
      err_q    <= err_d;
      second_q <= second_d;
    end
  end

`ifdef IMMENC_RANGE_CHECK_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && enc_err && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed-vector bench for imm_encoder; expected words are hand-encoded RV32I instructions.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_sel;
  logic [31:0] in_imm;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        out_err;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

`ifdef IMMENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  imm_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_imm    (in_imm),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_opcode (in_opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_last  (out_last),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request and returns #1 after the edge that accepted it.
  task automatic send(input logic [2:0] sel, input logic [31:0] imm, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] op);
    int n;
    in_sel = sel; in_imm = imm; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_opcode = op; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [31:0] instr,
                            input logic last, input logic err);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_instr"}, out_instr, instr);
    check({tag, "_last"},  {31'd0, out_last}, {31'd0, last});
    check({tag, "_err"},   {31'd0, out_err},  {31'd0, err});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sel = '0; in_imm = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_opcode = '0;
    repeat (3) tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_last",  {31'd0, out_last}, 32'd0);
    check("rst_err",   {31'd0, out_err}, 32'd0);
    check("rst_cnt",   {24'd0, err_cnt}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // I-format, one-cycle latency, then the register drains.
    send(3'd0, 32'hFFFF_FFFF, 5'd5, 5'd6, 5'd0, 3'd0, 7'h13);
    check_word("i_fmt", 32'hFFF3_0293, 1'b1, 1'b0);
    tick();
    check("i_drain", {31'd0, out_valid}, 32'd0);

    // Two-word LI.
    send(3'd6, 32'h1234_5FFF, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00);
    check_word("li_lui", 32'h1234_6537, 1'b0, 1'b0);
    check("li_ready0", {31'd0, in_ready}, 32'd0);
    tick();
    check_word("li_addi", 32'hFFF5_0513, 1'b1, 1'b0);
    tick();
    check("li_drain", {31'd0, out_valid}, 32'd0);

    // LI collapsing to one word: ADDI only, then LUI only.
    send(3'd6, 32'h0000_07FF, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00);
    check_word("li_addi_only", 32'h7FF0_0093, 1'b1, 1'b0);
    send(3'd6, 32'h0000_5000, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00);
    check_word("li_lui_only", 32'h0000_50B7, 1'b1, 1'b0);
    tick();

    // B-format under backpressure.
    out_ready = 1'b0;
    send(3'd3, 32'hFFFF_FFFC, 5'd0, 5'd1, 5'd2, 3'd0, 7'h63);
    for (int i = 0; i < 3; i++) begin
      check_word("b_hold", 32'hFE20_8EE3, 1'b1, 1'b0);
      check("b_hold_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("b_drain", {31'd0, out_valid}, 32'd0);

    // Back-to-back S then U at one word per cycle.
    send(3'd2, 32'h0000_0123, 5'd0, 5'd3, 5'd4, 3'd2, 7'h23);
    check_word("s_fmt", 32'h1241_A1A3, 1'b1, 1'b0);
    check("b2b_ready", {31'd0, in_ready}, 32'd1);
    send(3'd1, 32'hABCD_E000, 5'd7, 5'd0, 5'd0, 3'd0, 7'h37);
    check_word("u_fmt", 32'hABCD_E3B7, 1'b1, 1'b0);
    tick();

    // J with an out-of-range offset, then illegal sel.
    send(3'd4, 32'h0010_0000, 5'd1, 5'd0, 5'd0, 3'd0, 7'h6F);
    check_word("j_range", 32'h8000_00EF, 1'b1, RC);
    check("j_cnt", {24'd0, err_cnt}, RC ? 32'd1 : 32'd0);
    send(3'd7, 32'h0000_0000, 5'd3, 5'd3, 5'd3, 3'd7, 7'h7F);
    check_word("illegal", 32'h0000_0013, 1'b1, 1'b1);
    check("illegal_cnt", {24'd0, err_cnt}, RC ? 32'd2 : 32'd0);
    tick();

    // Reset while the second LI word is pending.
    out_ready = 1'b0;
    send(3'd6, 32'h1234_5FFF, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00);
    check("hold1_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_instr", out_instr, 32'd0);
    check("mid_rst_cnt", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    check("no_second_word", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the decode-stage immediate generator: packs a 32-bit immediate plus register/funct/opcode fields into a RISC-V RV32I instruction word, in I, U, S, B, J or load format.
- Also expands the `li` pseudo-op into LUI/ADDI, emitting one or two words.
- Feeds the boot-ROM / self-test program builder and the assembler-in-the-loop testbench.
- Valid/ready streaming on both sides, one registered output stage.

Parameters:
- NOP_WORD, 32'h00000013, word emitted for an illegal sel (ADDI x0,x0,0).
- CNT_W, 8, width of the saturating error counter (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_sel  in  3  format: 0=I, 1=U, 2=S, 3=B, 4=J, 5=L (load, I-layout), 6=LI pseudo, 7=illegal.
- in_imm  in  32  immediate (byte offset for B/J; full value for U/LI).
- in_rd  in  5  rd.
- in_rs1  in  5  rs1.
- in_rs2  in  5  rs2.
- in_funct3  in  3  funct3.
- in_opcode  in  7  opcode; ignored for LI, which uses 0110111/0010011.
- out_valid  out  1  out_instr valid.
- out_ready  in  1  downstream accept.
- out_instr  out  32  encoded instruction.
- out_last  out  1  last word of this request.
- out_err  out  1  request was illegal or its immediate was out of range.
- err_cnt  out  CNT_W  saturating error count (optional feature only).

Behaviour:
- Reset: all outputs 0 (out_valid=0, out_instr=0, out_last=0, out_err=0, err_cnt=0). FSM goes to IDLE; any pending second LI word is discarded.
- Field layouts:
  - I/L: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=f3, [11:7]=rd, [6:0]=op.
  - U: [31:12]=imm[31:12], rd, op.
  - S: [31:25]=imm[11:5], [24:20]=rs2, rs1, f3, [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], rs2, rs1, f3, [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], rd.
- LI expansion:
  - hi = imm[31:12] + imm[11], modulo 2^20.
  - If hi==0: single word ADDI rd,x0,imm[11:0].
  - Else if imm[11:0]==0: single word LUI rd,hi.
  - Else: LUI rd,hi, then ADDI rd,rd,imm[11:0].
- FSM states:
  - IDLE: output register empty.
  - HOLD: single word or last word presented.
  - HOLD1: first of two LI words presented; second word precomputed in an internal register.
- Transitions:
  - IDLE + accept -> HOLD or HOLD1.
  - HOLD1 + out_ready -> HOLD, with the second word loaded into the output register.
  - HOLD + out_ready -> IDLE, or directly HOLD/HOLD1 if a new request is accepted in the same cycle.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). It is 0 in HOLD1.
- Throughput and latency:
  - Sustained throughput is one word per cycle.
  - An accept in cycle N gives out_valid in cycle N+1.
- Backpressure: while out_valid && !out_ready, out_instr, out_last and out_err are held stable.
- out_last: 1 on every single-word request and on the second LI word; 0 on the first LI word.
- Illegal sel 7: emits NOP_WORD with out_last=1 and out_err=1. This happens regardless of the macro.
- Register fields are taken verbatim; x0 as rd is legal.

Optional Feature:
- Macro IMMENC_RANGE_CHECK_EN.
- When defined:
  - Legality rules:
    - I/L/S: imm[31:11] all equal.
    - B: imm[31:12] all equal and imm[0]==0.
    - J: imm[31:20] all equal and imm[0]==0.
    - U: imm[11:0]==0.
    - LI: always legal.
  - A violation still emits the truncated encoding, with out_err=1 on that word.
  - err_cnt increments once per erroneous request at acceptance, including sel 7, and saturates at all-ones.
- When undefined:
  - No range logic; out_err is set only for sel 7.
  - err_cnt is tied to 0.

Test Plan:
1. sel=0, imm=0xFFFFFFFF, rd=5, rs1=6, f3=0, op=0x13 -> out_instr=0xFFF30293, out_last=1, out_err=0, one cycle after accept.
2. sel=6, imm=0x12345FFF, rd=10 -> 0x12346537 (last=0), then 0xFFF50513 (last=1); in_ready=0 during the first word.
3. sel=6, imm=0x000007FF, rd=1 -> single word 0x7FF00093, last=1. Also imm=0x00005000, rd=1 -> single word 0x000050B7, last=1.
4. sel=3, imm=0xFFFFFFFC, rs1=1, rs2=2, f3=0, op=0x63 -> 0xFE208EE3. Hold out_ready=0 for 3 cycles: word stable, in_ready=0.
5. With macro: sel=4, imm=0x00100000 -> out_err=1, err_cnt 0->1; sel=7 -> NOP_WORD, err=1, err_cnt=2. Without macro: the sel=4 case gives out_err=0.
6. Deassert rst_n while in HOLD1 of an LI -> next cycle out_valid=0, in_ready=1; the second LI word is never emitted.
